input_port_buffer: RTL and testbench

Per-port input buffer of the mesh switch. It accepts single-flit packets from a neighbouring switch or local resource, queues them in a small FIFO, and splits the head packet into its column address, row address and payload. The addresses go to `xy_router`, whose `mux_out_sel_o` steers the head packet through the crossbar. The head packet is released once the crossbar/output side grants it.

---
 rtl/input_port_buffer_pkg.sv | 25 ++
 rtl/input_port_buffer_packet_fifo.sv | 61 ++++++
 rtl/input_port_buffer.sv | 59 +++++
 tb/tb_input_port_buffer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/input_port_buffer_pkg.sv
// rtl/input_port_buffer_pkg.sv - shared packet field widths and layout helpers for the input port buffer
package input_port_buffer_pkg;

    // Default packet layout, MSB to LSB: {col, row, data}
    localparam int DEF_COL_W        = 4;
    localparam int DEF_ROW_W        = 4;
    localparam int DEF_DATA_W       = 8;
    localparam int DEF_FIFO_DEPTH_W = 2;

    // Total packet width for a given field split
    function automatic int packet_width(input int col_w, input int row_w, input int data_w);
        return col_w + row_w + data_w;
    endfunction

    // Bit offset of the row field's LSB within a packet
    function automatic int row_lsb(input int data_w);
        return data_w;
    endfunction

    // Bit offset of the column field's LSB within a packet
    function automatic int col_lsb(input int row_w, input int data_w);
        return row_w + data_w;
    endfunction

endpackage

// File: rtl/input_port_buffer_packet_fifo.sv
// rtl/input_port_buffer_packet_fifo.sv - circular packet FIFO with first-word-fall-through head read
module input_port_buffer_packet_fifo #(
    parameter int DATA_W  = 16,
    parameter int DEPTH_W = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [DATA_W-1:0]  s_tdata,
    input  logic               s_tvalid,
    output logic               s_tready,
    output logic [DATA_W-1:0]  m_tdata,
    output logic               m_tvalid,
    input  logic               m_tready,
    output logic [DEPTH_W:0]   count
);

    localparam int               DEPTH      = 1 << DEPTH_W;
    localparam logic [DEPTH_W:0] FULL_COUNT = {1'b1, {DEPTH_W{1'b0}}};

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [DEPTH_W-1:0] wr_ptr;
    logic [DEPTH_W-1:0] rd_ptr;
    logic               push;
    logic               pop;

    // No bypass when full: a pop in the same cycle does not free a slot for this push
    assign s_tready = (count != FULL_COUNT);
    assign m_tvalid = (count != '0);
    assign push     = s_tvalid && s_tready;
    assign pop      = m_tvalid && m_tready;
    assign m_tdata  = mem[rd_ptr];

    // Storage is deliberately not reset; occupancy alone decides what is valid
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= s_tdata;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks push/pop balance
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/input_port_buffer.sv
// rtl/input_port_buffer.sv - per-port packet buffer that presents the head packet split into col/row/data
module input_port_buffer
    import input_port_buffer_pkg::*;
#(
    parameter int PACKET_ADDR_COL_W = DEF_COL_W,
    parameter int PACKET_ADDR_ROW_W = DEF_ROW_W,
    parameter int DATA_W            = DEF_DATA_W,
    parameter int FIFO_DEPTH_W      = DEF_FIFO_DEPTH_W
) (
    input  logic                                                    clk_i,
    input  logic                                                    rst_ni,
    input  logic [PACKET_ADDR_COL_W+PACKET_ADDR_ROW_W+DATA_W-1:0]   data_i,
    input  logic                                                    valid_i,
    output logic                                                    ready_o,
    output logic [PACKET_ADDR_COL_W-1:0]                            col_addr_o,
    output logic [PACKET_ADDR_ROW_W-1:0]                            row_addr_o,
    output logic [DATA_W-1:0]                                       data_o,
    output logic                                                    valid_o,
    input  logic                                                    ready_i,
    output logic [FIFO_DEPTH_W:0]                                   count_o
);

    localparam int PACKET_W = packet_width(PACKET_ADDR_COL_W, PACKET_ADDR_ROW_W, DATA_W);
    localparam int COL_LSB  = col_lsb(PACKET_ADDR_ROW_W, DATA_W);
    localparam int ROW_LSB  = row_lsb(DATA_W);

    logic [PACKET_W-1:0] head;
    logic                head_valid;

    input_port_buffer_packet_fifo #(
        .DATA_W  (PACKET_W),
        .DEPTH_W (FIFO_DEPTH_W)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .s_tdata  (data_i),
        .s_tvalid (valid_i),
        .s_tready (ready_o),
        .m_tdata  (head),
        .m_tvalid (head_valid),
        .m_tready (ready_i),
        .count    (count_o)
    );

    assign valid_o = head_valid;

    // Split the head packet into fields, forcing zeros while nothing is queued
    always_comb begin
        col_addr_o = '0;
        row_addr_o = '0;
        data_o     = '0;
        if (head_valid) begin
            col_addr_o = head[COL_LSB +: PACKET_ADDR_COL_W];
            row_addr_o = head[ROW_LSB +: PACKET_ADDR_ROW_W];
            data_o     = head[0 +: DATA_W];
        end
    end

endmodule

// File: tb/tb_input_port_buffer.sv
// tb/tb_input_port_buffer.sv - self-checking bench for input_port_buffer against a packet queue model
module tb_input_port_buffer;

    localparam int CW    = 4;
    localparam int RW    = 4;
    localparam int DW    = 8;
    localparam int DEPW  = 2;
    localparam int PW    = CW + RW + DW;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [PW-1:0] data_i;
    logic          valid_i;
    logic          ready_o;
    logic [CW-1:0] col_addr_o;
    logic [RW-1:0] row_addr_o;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          ready_i;
    logic [DEPW:0] count_o;

    int checks = 0;
    int errors = 0;

    logic [PW-1:0] model_q [$];

    typedef struct {
        logic [15:0] data;
        logic        vi;
        logic        ri;
        int          exp_count;
        logic        exp_valid;
        logic [15:0] exp_head;
        logic        exp_ready;
    } vec_t;

    vec_t vecs [12];

    always #5 clk = ~clk;

    input_port_buffer dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .data_i     (data_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .col_addr_o (col_addr_o),
        .row_addr_o (row_addr_o),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .count_o    (count_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Compare every output against what the packet queue says should be visible
    task automatic check_model(input string tag);
        logic [PW-1:0] head;
        int            n;
        n    = model_q.size();
        head = (n != 0) ? model_q[0] : '0;
        chk({tag, ".valid"}, 32'(valid_o), 32'(n != 0));
        chk({tag, ".ready"}, 32'(ready_o), 32'(n != DEPTH));
        chk({tag, ".count"}, 32'(count_o), 32'(n));
        chk({tag, ".head"},  32'({col_addr_o, row_addr_o, data_o}), 32'(head));
    endtask

    // One clock: decide push/pop from the queue's point of view, then advance
    task automatic step();
        logic do_push;
        logic do_pop;
        do_push = valid_i && (model_q.size() != DEPTH);
        do_pop  = ready_i && (model_q.size() != 0);
        @(posedge clk);
        if (do_pop)  void'(model_q.pop_front());
        if (do_push) model_q.push_back(data_i);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst_n   = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        data_i  = '0;
        model_q.delete();
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    initial begin
        logic [PW-1:0] sent [$];
        logic [PW-1:0] got [$];
        int            max_count;

        vecs[0]  = '{16'h1111, 1'b1, 1'b0, 1, 1'b1, 16'h1111, 1'b1};
        vecs[1]  = '{16'h2222, 1'b1, 1'b0, 2, 1'b1, 16'h1111, 1'b1};
        vecs[2]  = '{16'h3333, 1'b1, 1'b0, 3, 1'b1, 16'h1111, 1'b1};
        vecs[3]  = '{16'h4444, 1'b1, 1'b0, 4, 1'b1, 16'h1111, 1'b0};
        vecs[4]  = '{16'h5555, 1'b1, 1'b0, 4, 1'b1, 16'h1111, 1'b0};
        vecs[5]  = '{16'h6666, 1'b1, 1'b1, 3, 1'b1, 16'h2222, 1'b1};
        vecs[6]  = '{16'h7777, 1'b1, 1'b1, 3, 1'b1, 16'h3333, 1'b1};
        vecs[7]  = '{16'h0000, 1'b0, 1'b1, 2, 1'b1, 16'h4444, 1'b1};
        vecs[8]  = '{16'h8888, 1'b1, 1'b1, 2, 1'b1, 16'h7777, 1'b1};
        vecs[9]  = '{16'h0000, 1'b0, 1'b1, 1, 1'b1, 16'h8888, 1'b1};
        vecs[10] = '{16'h0000, 1'b0, 1'b1, 0, 1'b0, 16'h0000, 1'b1};
        vecs[11] = '{16'h0000, 1'b0, 1'b1, 0, 1'b0, 16'h0000, 1'b1};

        // Reset then idle
        do_reset(3);
        chk("reset.valid", 32'(valid_o), 32'd0);
        chk("reset.ready", 32'(ready_o), 32'd1);
        chk("reset.count", 32'(count_o), 32'd0);
        chk("reset.head",  32'({col_addr_o, row_addr_o, data_o}), 32'd0);
        step();
        check_model("idle");

        // Single packet held stable until granted
        data_i  = 16'h2A5C;
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        data_i  = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            chk("single.col",   32'(col_addr_o), 32'd2);
            chk("single.row",   32'(row_addr_o), 32'd10);
            chk("single.data",  32'(data_o),     32'h5C);
            chk("single.valid", 32'(valid_o),    32'd1);
            chk("single.count", 32'(count_o),    32'd1);
            step();
        end
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
        chk("single.popped", 32'(valid_o), 32'd0);

        // Table: fill to full, refused 5th, pop at full, push/pop at count 2, drain, empty pop
        for (int i = 0; i < 12; i++) begin
            data_i  = vecs[i].data;
            valid_i = vecs[i].vi;
            ready_i = vecs[i].ri;
            step();
            chk($sformatf("vec%0d.count", i), 32'(count_o), 32'(vecs[i].exp_count));
            chk($sformatf("vec%0d.valid", i), 32'(valid_o), 32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d.head",  i), 32'({col_addr_o, row_addr_o, data_o}), 32'(vecs[i].exp_head));
            chk($sformatf("vec%0d.ready", i), 32'(ready_o), 32'(vecs[i].exp_ready));
            check_model($sformatf("vec%0d.model", i));
        end
        valid_i = 1'b0;
        ready_i = 1'b0;

        // Stream 10 packets through with the output side always granting
        ready_i   = 1'b1;
        max_count = 0;
        for (int i = 0; i < 12; i++) begin
            valid_i = (i < 10);
            data_i  = PW'($urandom);
            if (valid_i && ready_o) sent.push_back(data_i);
            if (valid_o) got.push_back({col_addr_o, row_addr_o, data_o});
            step();
            if (int'(count_o) > max_count) max_count = int'(count_o);
        end
        valid_i = 1'b0;
        ready_i = 1'b0;
        chk("stream.sent",  32'(sent.size()), 32'd10);
        chk("stream.got",   32'(got.size()),  32'd10);
        chk("stream.maxcnt", 32'(max_count <= 1), 32'd1);
        for (int i = 0; i < 10 && i < got.size() && i < sent.size(); i++) begin
            chk($sformatf("stream.order%0d", i), 32'(got[i]), 32'(sent[i]));
        end
        check_model("stream.end");

        // Reset mid-operation at count 3: cleared immediately, old packets gone
        valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_i = 16'hA000 + 16'(i);
            step();
        end
        valid_i = 1'b0;
        chk("midrst.pre", 32'(count_o), 32'd3);
        #2;
        rst_n = 1'b0;
        model_q.delete();
        #1;
        chk("midrst.valid", 32'(valid_o), 32'd0);
        chk("midrst.count", 32'(count_o), 32'd0);
        chk("midrst.head",  32'({col_addr_o, row_addr_o, data_o}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        check_model("midrst.after");
        data_i  = 16'h3C3C;
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        chk("midrst.newhead", 32'({col_addr_o, row_addr_o, data_o}), 32'h3C3C);
        chk("midrst.newcnt",  32'(count_o), 32'd1);

        // Randomized traffic checked against the queue model
        for (int i = 0; i < 400; i++) begin
            valid_i = ($urandom_range(0, 99) < 55);
            ready_i = ($urandom_range(0, 99) < 45);
            data_i  = PW'($urandom);
            step();
            check_model("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
